// File: rtl/pipe_skid_stage.sv
// Valid/ready pipeline stage: either a two-entry skid buffer with registered
// in_ready or a single-entry stage with combinational in_ready, plus a stall counter.
module pipe_skid_stage #(
    parameter int unsigned      WIDTH   = 32,
    parameter bit               SKID_EN = 1'b1,
    parameter logic [WIDTH-1:0] BUBBLE  = '0,
    parameter int unsigned      CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] stall_count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] main_q, skid_q;
    logic             rdy_q;
    logic [CNT_W-1:0] stall_q;
    logic             push, pop;
    logic             load_main_in, load_main_skid, load_skid;

    assign out_valid   = (state_q != EMPTY);
    assign out_data    = out_valid ? main_q : BUBBLE;
    assign stall_count = stall_q;

    // Reset and flush gate acceptance combinationally in both modes.
    assign in_ready = ~reset & ~flush & (SKID_EN ? rdy_q : (~out_valid | out_ready));

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    always_comb begin
        occupancy = 2'd0;
        case (state_q)
            ONE:     occupancy = 2'd1;
            TWO:     occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

    always_comb begin
        state_d        = state_q;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (push) begin
                        state_d      = ONE;
                        load_main_in = 1'b1;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        load_main_in = 1'b1;
                    end else if (push) begin
                        // Only reachable with the skid entry present.
                        if (SKID_EN) begin
                            state_d   = TWO;
                            load_skid = 1'b1;
                        end
                    end else if (pop) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    if (pop) begin
                        state_d        = ONE;
                        load_main_skid = 1'b1;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= EMPTY;
            rdy_q   <= 1'b1;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            rdy_q   <= (state_d != TWO);
            if (out_valid && !out_ready && (stall_q != '1)) begin
                stall_q <= stall_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            if (load_main_in) begin
                main_q <= in_data;
            end else if (load_main_skid) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= in_data;
            end
        end
    end

endmodule
